// File: rtl/wrr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_pkg
//  Description : Shared types, reset constants and helpers for the weighted
//                round-robin grant scheduler.
//                  state_t     - scheduler FSM state (IDLE / HOLD)
//                  WEIGHT_RST  - reset value of every weight and credit
//                  PTR_RST     - reset value of the round-robin pointer
//                  onehot2idx  - one-hot (up to 16 bits) to binary index
//  Revision    : 1.0 - initial release
// ============================================================================
package wrr_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int WEIGHT_RST = 1;
    localparam int PTR_RST    = 0;

    // OR-reduction encoder: exact for one-hot inputs, 0 for an all-zero input.
    function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                r = r | 4'(i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wrr_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_rr_pick
//  Description : Combinational cyclic priority picker. Returns the first set
//                request bit found scanning ptr, ptr+1, ... (mod N).
//  Ports       : req    in  [N-1:0]   request vector
//                ptr    in  [IDW-1:0] scan start position
//                hit    out           any request present
//                idx    out [IDW-1:0] binary index of the winner
//                onehot out [N-1:0]   one-hot winner (0 when no hit)
//  Revision    : 1.0 - initial release
// ============================================================================
module wrr_rr_pick
    import wrr_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           hit,
    output logic [IDW-1:0] idx,
    output logic [N-1:0]   onehot
);

    // w_hi_oh: lowest request at or above ptr (no wrap needed).
    // w_lo_oh: lowest request overall, used when the scan has to wrap.
    logic [N-1:0] w_hi_oh;
    logic [N-1:0] w_lo_oh;

    always_comb begin
        w_hi_oh = '0;
        w_lo_oh = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                w_lo_oh    = '0;
                w_lo_oh[j] = 1'b1;
            end
            if (req[j] && (j >= int'(ptr))) begin
                w_hi_oh    = '0;
                w_hi_oh[j] = 1'b1;
            end
        end
    end

    assign hit    = |req;
    assign onehot = (|w_hi_oh) ? w_hi_oh : w_lo_oh;
    assign idx    = IDW'(onehot2idx(16'(onehot)));

endmodule
`default_nettype wire

// File: rtl/wrr_grant_sched.sv
`default_nettype none
// ============================================================================
//  Module      : wrr_grant_sched
//  Description : Weighted round-robin scheduler sharing one resource among N
//                requesters. A grant is held for a whole transaction and is
//                released by a done pulse; each requester may take up to
//                weight[i] back-to-back transactions before priority moves on.
//                Optional feature macro: WRR_TIMEOUT_EN (forced release after
//                TIMEOUT HOLD cycles without done, flagged on timeout_err).
//  Ports       : clk, rst (sync, active high)
//                req[N]          level-sensitive requests
//                done            transaction complete pulse
//                cfg_we/cfg_idx/cfg_weight  weight write port
//                grant[N], grant_id, grant_vld, timeout_err  (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module wrr_grant_sched
    import wrr_pkg::*;
#(
    parameter int N       = 4,
    parameter int CW      = 4,
    parameter int TIMEOUT = 64,
    localparam int IDW    = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           done,
    input  logic           cfg_we,
    input  logic [IDW-1:0] cfg_idx,
    input  logic [CW-1:0]  cfg_weight,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_vld,
    output logic           timeout_err
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   r_grant;
    logic [IDW-1:0] r_grant_id;
    logic [CW-1:0]  r_weight [N];
    logic [CW-1:0]  r_credit [N];

    logic           w_hit;
    logic [IDW-1:0] w_pick_idx;
    logic [N-1:0]   w_pick_oh;
    logic           w_take;
    logic           w_release;
    logic           w_tmo_hit;
    logic           w_tmo_rel;
    logic [CW-1:0]  w_cred_dec;
    logic [IDW-1:0] w_id_next;
    logic           w_cfg_ok;
    logic [CW-1:0]  w_cfg_val;

    wrr_rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .hit    (w_hit),
        .idx    (w_pick_idx),
        .onehot (w_pick_oh)
    );

    assign w_cred_dec = r_credit[r_grant_id] - CW'(1);
    assign w_id_next  = (32'(r_grant_id) == N - 1) ? '0 : r_grant_id + IDW'(1);
    assign w_cfg_ok   = cfg_we && (32'(cfg_idx) < N);
    assign w_cfg_val  = (cfg_weight == '0) ? CW'(1) : cfg_weight;

`ifdef WRR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;

    logic [TW-1:0] r_hold_cnt;
    logic          r_tmo_err;

    // Held at zero outside HOLD, so it always starts from zero on HOLD entry.
    always_ff @(posedge clk) begin
        if (rst || (r_state != HOLD)) begin
            r_hold_cnt <= '0;
        end else if (!done) begin
            r_hold_cnt <= r_hold_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_err <= w_tmo_rel;
        end
    end

    assign w_tmo_hit = (r_hold_cnt == TW'(TIMEOUT - 1));
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Next-state logic. A done arriving together with the timeout wins and
    // is treated as an ordinary completion.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_release   = 1'b0;
        w_tmo_rel   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_nxt = HOLD;
                    w_take      = 1'b1;
                end
            end
            HOLD: begin
                if (done || w_tmo_hit) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                    w_tmo_rel   = !done;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register plus pointer / credit / weight bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= IDW'(PTR_RST);
            r_grant    <= '0;
            r_grant_id <= '0;
            for (int i = 0; i < N; i++) begin
                r_weight[i] <= CW'(WEIGHT_RST);
                r_credit[i] <= CW'(WEIGHT_RST);
            end
        end else begin
            r_state <= w_state_nxt;

            if (w_cfg_ok) begin
                r_weight[cfg_idx] <= w_cfg_val;
            end

            if (w_take) begin
                r_grant    <= w_pick_oh;
                r_grant_id <= w_pick_idx;
                // The pointer holder was skipped: its remaining burst is lost.
                if (w_pick_idx != r_ptr) begin
                    r_credit[r_ptr] <= r_weight[r_ptr];
                end
            end

            if (w_release) begin
                r_grant    <= '0;
                r_grant_id <= '0;
                if (w_tmo_rel || (w_cred_dec == '0)) begin
                    r_credit[r_grant_id] <= r_weight[r_grant_id];
                    r_ptr                <= w_id_next;
                end else begin
                    r_credit[r_grant_id] <= w_cred_dec;
                    r_ptr                <= r_grant_id;
                end
            end
        end
    end

    // Output decode: everything visible is a register.
    always_comb begin
        grant     = r_grant;
        grant_id  = r_grant_id;
        grant_vld = |r_grant;
`ifdef WRR_TIMEOUT_EN
        timeout_err = r_tmo_err;
`else
        timeout_err = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_wrr_grant_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wrr_grant_sched
//  Description : Self-checking bench for wrr_grant_sched (N=4, CW=4,
//                TIMEOUT=64). A transaction-level reference model runs beside
//                the DUT and every cycle's outputs are compared; directed
//                scenarios add literal expectations on grant order and timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wrr_grant_sched;

    localparam int N       = 4;
    localparam int CW      = 4;
    localparam int TIMEOUT = 64;
`ifdef WRR_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       done = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [3:0] cfg_weight = '0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       grant_vld;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    wrr_grant_sched #(
        .N       (N),
        .CW      (CW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .done        (done),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_weight  (cfg_weight),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_vld   (grant_vld),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who holds the resource, remaining burst per
    // requester, and where the round-robin scan starts.
    // ------------------------------------------------------------------
    int m_w [N];
    int m_c [N];
    int m_ptr, m_g, m_hold;
    bit m_busy, m_terr;

    function automatic int pick(input int r, input int p);
        for (int k = 0; k < N; k++) begin
            if (((r >> ((p + k) % N)) & 1) != 0) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_w[i] = 1;
                m_c[i] = 1;
            end
            m_ptr = 0; m_g = 0; m_busy = 0; m_terr = 0; m_hold = 0;
        end else begin
            bit tmo;
            m_terr = 0;
            if (!m_busy) begin
                if (req != 0) begin
                    int g;
                    g = pick(int'(req), m_ptr);
                    if (g != m_ptr) m_c[m_ptr] = m_w[m_ptr];
                    m_g = g; m_busy = 1; m_hold = 0;
                end
            end else begin
                tmo = TMO_EN && !done && (m_hold == TIMEOUT - 1);
                if (done || tmo) begin
                    if (tmo) begin
                        m_c[m_g] = m_w[m_g];
                        m_ptr    = (m_g + 1) % N;
                        m_terr   = 1;
                    end else begin
                        m_c[m_g] = m_c[m_g] - 1;
                        if (m_c[m_g] == 0) begin
                            m_c[m_g] = m_w[m_g];
                            m_ptr    = (m_g + 1) % N;
                        end else begin
                            m_ptr = m_g;
                        end
                    end
                    m_busy = 0;
                end else begin
                    m_hold++;
                end
            end
            // weight writes land after this edge's reloads have used the old value
            if (cfg_we) m_w[cfg_idx] = (cfg_weight == 0) ? 1 : int'(cfg_weight);
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare plus grant-event log (id and low-cycle gap).
    // ------------------------------------------------------------------
    bit chk_en = 1'b0;
    bit prev_vld = 1'b0;
    int gap = 0;
    int q_ids[$];
    int q_gaps[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant", int'(grant), m_busy ? (1 << m_g) : 0);
            chk("grant_vld", int'(grant_vld), int'(m_busy));
            if (m_busy) chk("grant_id", int'(grant_id), m_g);
            chk("timeout_err", int'(timeout_err), int'(m_terr));
            if (grant_vld && !prev_vld) begin
                q_ids.push_back(int'(grant_id));
                q_gaps.push_back(gap);
            end
            gap      = grant_vld ? 0 : gap + 1;
            prev_vld = grant_vld;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; done = 1'b0; cfg_we = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        q_ids.delete();
        q_gaps.delete();
    endtask

    task automatic cfg_write(input int idx, input int w);
        cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_weight = 4'(w);
        tick();
        cfg_we = 1'b0;
    endtask

    // Wait for a grant, keep it for 'hold' visible cycles, then pulse done.
    task automatic serve(input int hold);
        int t;
        t = 0;
        while (!grant_vld && t < 50) begin
            tick();
            t++;
        end
        if (!grant_vld) begin
            chk("grant_wait_expired", 0, 1);
            return;
        end
        repeat (hold - 1) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic chk_seq(input string nm, input int exp[], input bit gaps);
        chk({nm, "_count_ok"}, int'(q_ids.size() >= exp.size()), 1);
        for (int i = 0; i < exp.size() && i < q_ids.size(); i++) begin
            chk($sformatf("%s_id%0d", nm, i), q_ids[i], exp[i]);
            if (gaps && i > 0) chk($sformatf("%s_gap%0d", nm, i), q_gaps[i], 1);
        end
    endtask

    initial begin
        int n;

        // 1: equal weights, full request -> plain rotation, one idle cycle between grants
        do_reset();
        chk("rst_grant", int'(grant), 0);
        chk("rst_vld", int'(grant_vld), 0);
        chk("rst_id", int'(grant_id), 0);
        req = 4'b1111;
        repeat (5) serve(2);
        chk_seq("t1", '{0, 1, 2, 3, 0}, 1'b1);

        // 2: weight[1]=3 applies once requester 1's credit reloads (after its first grant)
        do_reset();
        cfg_write(1, 3);
        req = 4'b1111;
        repeat (9) serve(2);
        chk_seq("t2", '{0, 1, 2, 3, 0, 1, 1, 1, 2}, 1'b1);

        // 3: lone requester 2; weight[2] written as 0 must behave as weight 1
        do_reset();
        cfg_write(2, 0);
        req = 4'b0100;
        tick();
        chk("t3_latency_vld", int'(grant_vld), 1);
        chk("t3_latency_id", int'(grant_id), 2);
        repeat (3) serve(2);
        req = 4'b1111;
        tick();
        chk_seq("t3", '{2, 2, 2, 3}, 1'b0);

        // 4: dropped request does not release; done while idle is ignored
        do_reset();
        req = 4'b0010;
        tick();
        chk("t4_id", int'(grant_id), 1);
        req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold", int'(grant), 4'b0010);
        end
        done = 1'b1; tick(); done = 1'b0;
        chk("t4_released", int'(grant), 0);
        repeat (3) begin
            done = 1'b1; tick(); done = 1'b0; tick();
        end
        chk("t4_idle_done", int'(grant_vld), 0);
        req = 4'b1111;
        tick();
        chk("t4_next_id", int'(grant_id), 2);

        // 5: requester 0 never completes
        do_reset();
        req = 4'b0001;
        tick();
        chk("t5_grant0", int'(grant), 4'b0001);
        req = 4'b1111;
        if (TMO_EN) begin
            n = 0;
            while (grant_vld && n < 100) begin
                n++;
                tick();
            end
            chk("t5_hold_cycles", n, 64);
            chk("t5_terr_pulse", int'(timeout_err), 1);
            tick();
            chk("t5_terr_clear", int'(timeout_err), 0);
        end else begin
            repeat (210) tick();
            chk("t5_still_held", int'(grant), 4'b0001);
            done = 1'b1; tick(); done = 1'b0;
            tick();
        end
        chk("t5_next_id", int'(grant_id), 1);

        // 6: reset in the middle of a hold
        do_reset();
        req = 4'b0100;
        tick();
        chk("t6_id", int'(grant_id), 2);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_grant", int'(grant), 0);
        chk("t6_rst_vld", int'(grant_vld), 0);
        tick();
        rst = 1'b0;
        req = 4'b1111;
        tick();
        chk("t6_first_id", int'(grant_id), 0);

        req = '0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
